// File: rtl/icache_pkg.sv
// Shared types and sizing for the I-cache refill path.
// Optional miss merging is enabled with ICACHE_MISS_MERGE_EN.
package icache_pkg;

    localparam int unsigned TAG_WIDTH   = 7;
    localparam int unsigned NUM_SET     = 32;
    localparam int unsigned NUM_WAY     = 2;
    localparam int unsigned SET_DEPTH   = 5;
    localparam int unsigned NUM_WARP    = 8;
    localparam int unsigned WARP_DEPTH  = 3;
    localparam int unsigned LINE_WIDTH  = 128;
    localparam int unsigned QUEUE_DEPTH = 4;
    localparam int unsigned QUEUE_PTR   = 2;
    localparam int unsigned ADDR_WIDTH  = TAG_WIDTH + SET_DEPTH;

    typedef logic [1:0] refill_state_e;
    localparam refill_state_e StIdle  = 2'd0;
    localparam refill_state_e StReq   = 2'd1;
    localparam refill_state_e StWait  = 2'd2;
    localparam refill_state_e StWrite = 2'd3;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic [SET_DEPTH-1:0] setid;
        logic [NUM_WARP-1:0]  mask;
    } miss_entry_t;

    function automatic logic [NUM_WARP-1:0] warp_onehot(input logic [WARP_DEPTH-1:0] wid);
        return NUM_WARP'(1) << wid;
    endfunction

endpackage

// File: rtl/icache_miss_queue.sv
// Pending-miss FIFO of miss_entry_t with flush; with ICACHE_MISS_MERGE_EN it also
// reports per-entry line matches and ORs a warp mask into matching entries.
module icache_miss_queue
    import icache_pkg::*;
#(
    parameter int unsigned Depth = QUEUE_DEPTH,
    parameter int unsigned PtrW  = QUEUE_PTR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  miss_entry_t          push_data_i,
    input  logic                 pop_i,
    output miss_entry_t          pop_data_o,
    output logic                 full_o,
    output logic                 empty_o
`ifdef ICACHE_MISS_MERGE_EN
    ,
    input  logic [TAG_WIDTH-1:0] match_tag_i,
    input  logic [SET_DEPTH-1:0] match_setid_i,
    output logic [Depth-1:0]     match_o,
    input  logic                 merge_i,
    input  logic [NUM_WARP-1:0]  merge_mask_i
`endif
);

    miss_entry_t         mem_q [Depth];
    logic [PtrW-1:0]     wptr_q, rptr_q;
    logic [PtrW:0]       count_q;
    logic                do_push, do_pop;

    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

`ifdef ICACHE_MISS_MERGE_EN
    for (genvar g = 0; g < Depth; g++) begin : g_match
        logic [PtrW-1:0] off;
        assign off = PtrW'(g) - rptr_q;
        assign match_o[g] = ({1'b0, off} < count_q) && (mem_q[g].tag == match_tag_i) &&
                            (mem_q[g].setid == match_setid_i);
    end
`endif

    // A merge into the head while it is being popped must reach the popped copy.
    always_comb begin
        pop_data_o = mem_q[rptr_q];
`ifdef ICACHE_MISS_MERGE_EN
        if (merge_i && match_o[rptr_q]) begin
            pop_data_o.mask = pop_data_o.mask | merge_mask_i;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW+1)'(1);
                2'b01:   count_q <= count_q - (PtrW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
`ifdef ICACHE_MISS_MERGE_EN
        for (int i = 0; i < Depth; i++) begin
            if (merge_i && match_o[i]) mem_q[i].mask <= mem_q[i].mask | merge_mask_i;
        end
`endif
        if (do_push) mem_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss handler: queues misses, fetches lines, writes tag/data arrays and wakes warps.
// Define ICACHE_MISS_MERGE_EN to merge misses to a line already pending.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic                           miss_valid_i,
    output logic                           miss_ready_o,
    input  logic [SET_DEPTH-1:0]           miss_setid_i,
    input  logic [TAG_WIDTH-1:0]           miss_tag_i,
    input  logic [WARP_DEPTH-1:0]          miss_wid_i,
    output logic                           mem_req_valid_o,
    input  logic                           mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]          mem_req_addr_o,
    input  logic                           mem_rsp_valid_i,
    input  logic [LINE_WIDTH-1:0]          mem_rsp_data_i,
    output logic                           tag_w_valid_o,
    output logic [SET_DEPTH-1:0]           tag_w_setid_o,
    output logic [NUM_WAY*TAG_WIDTH-1:0]   tag_w_data_o,
    output logic [LINE_WIDTH-1:0]          data_w_data_o,
    output logic                           wakeup_valid_o,
    output logic [NUM_WARP-1:0]            wakeup_mask_o,
    output logic                           busy_o
);

    refill_state_e         state_q, state_d;
    miss_entry_t           inflight_q, inflight_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic                  drop_q, drop_d;

    miss_entry_t           miss_entry, q_head;
    logic                  q_push, q_pop, q_full, q_empty;

    assign miss_entry = '{tag: miss_tag_i, setid: miss_setid_i, mask: warp_onehot(miss_wid_i)};

`ifdef ICACHE_MISS_MERGE_EN
    logic [QUEUE_DEPTH-1:0] q_match;
    logic                   inflight_match, any_match, merge;

    // A line already being written is not merged: its wakeup mask is final.
    assign inflight_match = ((state_q == StReq) || (state_q == StWait)) && !drop_q &&
                            (inflight_q.tag == miss_tag_i) && (inflight_q.setid == miss_setid_i);
    assign any_match    = inflight_match || (|q_match);
    assign miss_ready_o = (!q_full || any_match) && !flush_i;
    assign merge        = miss_valid_i && miss_ready_o && any_match;
    assign q_push       = miss_valid_i && miss_ready_o && !any_match;
`else
    assign miss_ready_o = !q_full && !flush_i;
    assign q_push       = miss_valid_i && miss_ready_o;
`endif

    icache_miss_queue #(
        .Depth (QUEUE_DEPTH),
        .PtrW  (QUEUE_PTR)
    ) u_miss_queue (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .push_i        (q_push),
        .push_data_i   (miss_entry),
        .pop_i         (q_pop),
        .pop_data_o    (q_head),
        .full_o        (q_full),
        .empty_o       (q_empty)
`ifdef ICACHE_MISS_MERGE_EN
        ,
        .match_tag_i   (miss_tag_i),
        .match_setid_i (miss_setid_i),
        .match_o       (q_match),
        .merge_i       (merge && !inflight_match),
        .merge_mask_i  (miss_entry.mask)
`endif
    );

    always_comb begin
        state_d    = state_q;
        inflight_d = inflight_q;
        line_d     = line_q;
        drop_d     = drop_q;
        q_pop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!q_empty && !flush_i) begin
                    q_pop      = 1'b1;
                    inflight_d = q_head;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (mem_req_ready_i) begin
                    // Request already left: let the response come back and discard it.
                    state_d = StWait;
                    drop_d  = flush_i;
                end else if (flush_i) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (flush_i) drop_d = 1'b1;
                if (mem_rsp_valid_i) begin
                    line_d  = mem_rsp_data_i;
                    drop_d  = 1'b0;
                    state_d = (drop_q || flush_i) ? StIdle : StWrite;
                end
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
`ifdef ICACHE_MISS_MERGE_EN
        if (merge && inflight_match) inflight_d.mask = inflight_q.mask | miss_entry.mask;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            inflight_q <= '0;
            line_q     <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            line_q     <= line_d;
            drop_q     <= drop_d;
        end
    end

    assign mem_req_valid_o = (state_q == StReq);
    assign mem_req_addr_o  = mem_req_valid_o ? {inflight_q.tag, inflight_q.setid} : '0;
    assign tag_w_valid_o   = (state_q == StWrite);
    assign tag_w_setid_o   = tag_w_valid_o ? inflight_q.setid : '0;
    assign tag_w_data_o    = tag_w_valid_o ? {NUM_WAY{inflight_q.tag}} : '0;
    assign data_w_data_o   = tag_w_valid_o ? line_q : '0;
    assign wakeup_valid_o  = tag_w_valid_o;
    assign wakeup_mask_o   = tag_w_valid_o ? inflight_q.mask : '0;
    assign busy_o          = !q_empty || (state_q != StIdle);

endmodule
